// File: rtl/fft_input_loader_pkg.sv
// fft_input_loader_pkg: widths, frame length and loader state encoding shared by the loader files
package fft_input_loader_pkg;
    localparam int D_BIT   = 16;
    localparam int A_BIT   = 9;
    localparam int N_POINT = 2048;
    localparam int IDX_W   = A_BIT + 2;
    typedef enum logic [1:0] {ST_LOAD, ST_FLUSH, ST_START, ST_BUSY} state_t;
endpackage

// File: rtl/fft_loader_bank_dec.sv
// fft_loader_bank_dec: 2-bit bank select plus write strobe to one-hot bank write enables
module fft_loader_bank_dec (
    input  logic [1:0] bank_i,
    input  logic       we_i,
    output logic [3:0] we_o
);
    assign we_o = we_i ? 4'b0001 << bank_i : 4'b0000;
endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: streams one real frame into the four RAM_A banks, then starts fft_top and waits.
// Optional FFT_LOADER_DROP_CNT_EN: always ready, samples offered outside LOAD are dropped and counted.
module fft_input_loader
    import fft_input_loader_pkg::*;
(
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iCLR,
    input  logic [D_BIT-1:0] iSAMPLE,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic             iFFT_RDY,
    output logic [D_BIT-1:0] oDATA,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic             oSTART,
    output logic             oBUSY
`ifdef FFT_LOADER_DROP_CNT_EN
    ,
    output logic [15:0]      oDROP_CNT
`endif
);
    if (N_POINT != 4 * 2**A_BIT) begin : g_len_chk
        $error("N_POINT must equal 4*2**A_BIT");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             arm_q, we_q, start_q;
    logic [1:0]       bank_q;
    logic [A_BIT-1:0] addr_q;
    logic [D_BIT-1:0] data_q;
    logic [3:0]       we_vec;
    logic             in_load, hs;

    assign in_load = state_q == ST_LOAD;
    assign hs      = iVALID && in_load && !iCLR;
    assign oBUSY   = state_q == ST_BUSY;
`ifdef FFT_LOADER_DROP_CNT_EN
    assign oREADY  = 1'b1;
`else
    assign oREADY  = in_load;
`endif

    // Next state and index: the last sample wraps idx to 0; iCLR overrides everything.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_LOAD: begin
                idx_d   = hs ? idx_q + 1'b1 : idx_q;
                state_d = hs && idx_q == IDX_W'(N_POINT - 1) ? ST_FLUSH : ST_LOAD;
            end
            ST_FLUSH: state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            default: begin
                state_d = arm_q && iFFT_RDY ? ST_LOAD : ST_BUSY;
                idx_d   = '0;
            end
        endcase
        if (iCLR) begin
            state_d = ST_LOAD;
            idx_d   = '0;
        end
    end

    // State, registered write port and start pulse; arm_q masks the stale done in the first BUSY cycle.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            arm_q   <= 1'b0;
            we_q    <= 1'b0;
            start_q <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            arm_q   <= state_q == ST_BUSY;
            we_q    <= hs;
            start_q <= state_q == ST_START && !iCLR;
            if (hs) begin
                bank_q <= idx_q[IDX_W-1:A_BIT];
                addr_q <= idx_q[A_BIT-1:0];
                data_q <= iSAMPLE;
            end
        end
    end

`ifdef FFT_LOADER_DROP_CNT_EN
    logic [15:0] drop_q;

    // Saturating count of samples offered while the frame buffer is not accepting.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) drop_q <= '0;
        else if (iCLR) drop_q <= '0;
        else if (iVALID && !in_load && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end

    assign oDROP_CNT = drop_q;
`endif

    fft_loader_bank_dec u_bank_dec (
        .bank_i (bank_q),
        .we_i   (we_q),
        .we_o   (we_vec)
    );

    assign {oWE_3, oWE_2, oWE_1, oWE_0} = we_vec;
    assign oADDR_WR_0 = addr_q;
    assign oADDR_WR_1 = addr_q;
    assign oADDR_WR_2 = addr_q;
    assign oADDR_WR_3 = addr_q;
    assign oDATA      = data_q;
    assign oSTART     = start_q;
endmodule
